// File: rtl/link_mm_initiator.sv
// Single-outstanding request/response bridge onto a strobe-based register bus.
// A read that sees no data valid within TIMEOUT_CYC wait cycles is answered with ERR_DATA.
module link_mm_initiator #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [63:0] ERR_DATA    = 64'hDEAD_DEAD_DEAD_DEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WR,
  input  logic [16:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [63:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        oMM_WR_EN,
  output logic        oMM_RD_EN,
  output logic [16:0] oMM_ADDR,
  output logic [63:0] oMM_WR_DATA,
  input  logic [63:0] iMM_RD_DATA,
  input  logic        iMM_RD_DATA_V,
  output logic [7:0]  STRAY_CNT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic        wr_q;
  logic [16:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic [15:0] wait_cnt;
  logic [7:0]  stray_q;
  logic        accept;
  logic        rd_hit;
  logic        rd_timeout;

  // Ready is held low while reset is asserted so nothing is offered before release.
  assign REQ_READY  = (state == IDLE) && rst_n;
  assign accept     = REQ_VALID && REQ_READY;
  assign rd_hit     = (state == WAIT) && iMM_RD_DATA_V;
  assign rd_timeout = (state == WAIT) && !iMM_RD_DATA_V && (wait_cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = wr_q ? RESP : WAIT;
      WAIT:    if (rd_hit || rd_timeout) state_nxt = RESP;
      RESP:    if (RSP_READY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= REQ_WR;
      addr_q  <= REQ_ADDR;
      wdata_q <= REQ_WDATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Data valid wins over timeout when both land in the same wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ISSUE) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (rd_hit) begin
      rdata_q <= iMM_RD_DATA;
      err_q   <= 1'b0;
    end else if (rd_timeout) begin
      rdata_q <= ERR_DATA;
      err_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stray_q <= '0;
    end else if (iMM_RD_DATA_V && (state != WAIT) && (stray_q != 8'hFF)) begin
      stray_q <= stray_q + 8'd1;
    end
  end

  assign oMM_WR_EN   = (state == ISSUE) && wr_q;
  assign oMM_RD_EN   = (state == ISSUE) && !wr_q;
  assign oMM_ADDR    = addr_q;
  assign oMM_WR_DATA = wdata_q;
  assign RSP_VALID   = (state == RESP);
  assign RSP_RDATA   = rdata_q;
  assign RSP_ERR     = err_q;
  assign STRAY_CNT   = stray_q;

endmodule

// File: doc/link_mm_initiator.md
LINK_MM_INITIATOR -- requirements
Module: link_mm_initiator

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64: maximum cycles to wait for read data; legal range 4..65535.
REQ-002 Parameter ERR_DATA, default 64'hDEAD_DEAD_DEAD_DEAD: RSP_RDATA value returned on read timeout.
REQ-003 Ports, in this order:
  - clk  in  1  single clock; all logic on its rising edge.
  - rst_n  in  1  asynchronous, active-low reset.
  - REQ_VALID  in  1  upstream request present.
  - REQ_READY  out  1  block accepts a request.
  - REQ_WR  in  1  1=write, 0=read.
  - REQ_ADDR  in  17  register address.
  - REQ_WDATA  in  64  write data.
  - RSP_VALID  out  1  response present.
  - RSP_READY  in  1  upstream accepts the response.
  - RSP_RDATA  out  64  read data; 0 for writes.
  - RSP_ERR  out  1  read timed out.
  - oMM_WR_EN  out  1  write strobe to the register bus.
  - oMM_RD_EN  out  1  read strobe to the register bus.
  - oMM_ADDR  out  17  bus address.
  - oMM_WR_DATA  out  64  bus write data.
  - iMM_RD_DATA  in  64  bus read data.
  - iMM_RD_DATA_V  in  1  bus read data valid, single-cycle pulse.
  - STRAY_CNT  out  8  saturating count of unexpected iMM_RD_DATA_V pulses.

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-005 REQ_READY SHALL be 1 only in IDLE; accept = REQ_VALID & REQ_READY.
REQ-006 On accept, the block SHALL register REQ_WR, REQ_ADDR and REQ_WDATA and go to ISSUE.
REQ-007 In ISSUE, for exactly one cycle, the block SHALL assert oMM_WR_EN (write) or oMM_RD_EN (read), never both.
REQ-008 oMM_ADDR and oMM_WR_DATA SHALL hold the registered request from ISSUE until the next accept.
REQ-009 Write, ISSUE -> RESP:
  - RSP_RDATA = 0, RSP_ERR = 0.
  - Accept-to-RSP_VALID latency is 2 cycles.
REQ-010 Read, ISSUE -> WAIT:
  - A 16-bit wait counter SHALL clear in ISSUE.
  - The counter SHALL increment each WAIT cycle.
REQ-011 In WAIT, when iMM_RD_DATA_V = 1:
  - Capture iMM_RD_DATA into RSP_RDATA, set RSP_ERR = 0, go to RESP the next cycle.
  - This SHALL take precedence over timeout in the same cycle.
REQ-012 In WAIT, when counter = TIMEOUT_CYC-1 and no valid: RSP_RDATA = ERR_DATA, RSP_ERR = 1, go to RESP.
REQ-013 In RESP:
  - RSP_VALID SHALL be 1 and RSP_RDATA/RSP_ERR SHALL be stable.
  - On RSP_READY = 1, the block SHALL return to IDLE.
  - REQ_READY SHALL rise the cycle after the response handshake, so there is no same-cycle re-accept.
REQ-014 STRAY_CNT SHALL increment on any iMM_RD_DATA_V outside WAIT, including the late valid after a timeout.
REQ-015 STRAY_CNT SHALL saturate at 255; a stray valid SHALL NOT change RSP_RDATA or the FSM.
REQ-016 At most one transaction SHALL be outstanding; throughput is one transaction per at least 3 cycles (write with RSP_READY held 1).

Reset
REQ-017 On rst_n = 0, asynchronously:
  - FSM = IDLE.
  - All outputs 0, except REQ_READY = 1 after release.
  - Counters and captured request cleared.
REQ-018 Reset mid-WAIT or mid-RESP SHALL drop the transaction with no response; no strobe is issued after rst_n rises until a new accept.

Verification
REQ-019 Write 0x00010 / 64'h1234: exactly one oMM_WR_EN with oMM_ADDR = 17'h00010; RSP_VALID two cycles after accept; RSP_ERR = 0.
REQ-020 Read 0x08004, bus returns valid 3 cycles after oMM_RD_EN with data 64'hCAFE: RSP_RDATA = 64'hCAFE, RSP_ERR = 0.
REQ-021 Read with no valid, TIMEOUT_CYC = 64: RSP_ERR = 1 and RSP_RDATA = ERR_DATA; late valid -> STRAY_CNT = 1.
REQ-022 RSP_READY held 0 for 10 cycles: RSP_VALID and data stable; REQ_READY = 0 throughout; REQ_VALID held meanwhile is not accepted.
REQ-023 300 stray valids in IDLE: STRAY_CNT = 255; the next read completes normally.
REQ-024 rst_n pulse in WAIT: no RSP_VALID; outputs 0; the next request completes normally.
